// File: rtl/apb_slave_regfile.sv
// APB slave with a four-entry register file (DATA0, DATA1, CTRL, STATUS) and error/write counters.
// Latency: pready in access cycle WAIT_STATES+1; pready/prdata/pslverr are registered.
// Backpressure: the slave stretches each transfer with WAIT_STATES wait cycles; dropping psel mid-transfer aborts it.
module apb_slave_regfile #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SETUP_SEEN = 2'd1,
        WAIT       = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [3:0] WS_CNT   = 4'(WAIT_STATES);
    // With no wait states the setup edge lands directly in DONE so pready shows in the first access cycle.
    localparam state_t     FIRST_ST = (WAIT_STATES == 0) ? DONE : SETUP_SEEN;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    // Transfer attributes captured at the setup edge; the bus may change afterwards.
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;

    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;

    logic        setup_phase;
    logic        access_phase;
    logic        capture;

    assign setup_phase  = psel & ~penable;
    assign access_phase = psel & penable;
    assign capture      = setup_phase & ((state_q == IDLE) | (state_q == DONE));

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

    // Misaligned, out-of-map, or a write to the read-only STATUS register.
    function automatic logic addr_err(input logic [7:0] a, input logic w);
        return (a[1:0] != 2'b00) || (a >= 8'h10) || (w && (a == 8'h0C));
    endfunction

    // Next-state logic; wait_cnt counts down the access cycles spent in SETUP_SEEN and WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    state_d = FIRST_ST;
                end
            end
            SETUP_SEEN, WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    state_d    = (wait_cnt_q == 4'd1) ? DONE : WAIT;
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = setup_phase ? FIRST_ST : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The count is loaded when the setup is accepted, so SETUP_SEEN is the first counted cycle.
        if (capture) begin
            wait_cnt_d = WS_CNT;
        end
    end

    // Datapath and output next values: commit in DONE, registered response for the cycle entering DONE.
    always_comb begin
        logic        commit_err;
        logic        wr_ok;
        logic        nxt_err;
        logic [31:0] rd_mux;

        addr_d  = capture ? paddr   : addr_q;
        write_d = capture ? pwrite  : write_q;
        wdata_d = capture ? pwdata  : wdata_q;
        strb_d  = capture ? pstrb   : strb_q;

        commit_err = (state_q == DONE) && addr_err(addr_q, write_q);
        wr_ok      = (state_q == DONE) && write_q && !addr_err(addr_q, write_q);

        data0_d   = data0_q;
        data1_d   = data1_q;
        ctrl_d    = ctrl_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;

        if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    if (addr_q[3:2] == 2'd0) data0_d[8*i +: 8] = wdata_q[8*i +: 8];
                    if (addr_q[3:2] == 2'd1) data1_d[8*i +: 8] = wdata_q[8*i +: 8];
                end
            end
            if ((addr_q[3:2] == 2'd2) && strb_q[0]) begin
                ctrl_d = wdata_q[7:0];
            end
            if (wr_cnt_q != 16'hFFFF) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
        if (commit_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // Read from next-state values so a commit on the same edge is already visible.
        unique case (addr_d[3:2])
            2'd0:    rd_mux = data0_d;
            2'd1:    rd_mux = data1_d;
            2'd2:    rd_mux = {24'd0, ctrl_d};
            default: rd_mux = {err_cnt_d, wr_cnt_d};
        endcase

        nxt_err   = addr_err(addr_d, write_d);
        pready_d  = (state_d == DONE);
        pslverr_d = pready_d && nxt_err;
        prdata_d  = (pready_d && !write_d && !nxt_err) ? rd_mux : 32'd0;
    end

    // FSM, captured transfer and response registers; reset wins over everything.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 8'd0;
            write_q    <= 1'b0;
            wdata_q    <= 32'd0;
            strb_q     <= 4'd0;
            pready_q   <= 1'b0;
            prdata_q   <= 32'd0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
        end
    end

    // Register file and saturating counters.
    always_ff @(posedge pclk) begin
        if (preset) begin
            data0_q   <= 32'd0;
            data1_q   <= 32'd0;
            ctrl_q    <= 8'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            ctrl_q    <= ctrl_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (WAIT_STATES 1, 0, 3) driven by directed and random APB traffic.
// Expected responses come from a register-map model and are queued per instance at issue time.
// A monitor pops and compares on every pready; latency and idle-zero prdata are also checked.
module tb_apb_slave_regfile;

    localparam int NDUT = 3;
    localparam int WS_OF [NDUT] = '{1, 0, 3};

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel_s    [NDUT];
    logic        pen_s     [NDUT];
    logic        pwr_s     [NDUT];
    logic [7:0]  paddr_s   [NDUT];
    logic [31:0] pwdata_s  [NDUT];
    logic [3:0]  pstrb_s   [NDUT];
    logic        pready_s  [NDUT];
    logic [31:0] prdata_s  [NDUT];
    logic        pslverr_s [NDUT];

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t exp_q [NDUT][$];

    // Reference model: architectural register contents and counters per instance.
    logic [31:0] m_d0   [NDUT];
    logic [31:0] m_d1   [NDUT];
    logic [7:0]  m_ctrl [NDUT];
    int          m_wrc  [NDUT];
    int          m_errc [NDUT];

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_regfile #(.WAIT_STATES(WS_OF[g])) u_dut (
            .pclk    (pclk),
            .preset  (preset),
            .psel    (psel_s[g]),
            .penable (pen_s[g]),
            .pwrite  (pwr_s[g]),
            .paddr   (paddr_s[g]),
            .pwdata  (pwdata_s[g]),
            .pstrb   (pstrb_s[g]),
            .pready  (pready_s[g]),
            .prdata  (prdata_s[g]),
            .pslverr (pslverr_s[g])
        );
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] st);
        return {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_d0[d] = 0; m_d1[d] = 0; m_ctrl[d] = 0; m_wrc[d] = 0; m_errc[d] = 0;
            exp_q[d].delete();
        end
    endtask

    // Apply one completed transfer to the model and queue the response the bus should show.
    task automatic push_expect(input int d, input bit wr, input logic [7:0] a,
                               input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        logic [31:0] m;
        e.dat = 0;
        e.err = 0;
        m = lane_mask(st);
        if (a % 4 != 0 || a >= 16 || (wr && a == 12)) begin
            e.err = 1;
            if (m_errc[d] < 65535) m_errc[d]++;
        end else if (wr) begin
            if (a == 0) m_d0[d] = (m_d0[d] & ~m) | (wd & m);
            if (a == 4) m_d1[d] = (m_d1[d] & ~m) | (wd & m);
            if (a == 8 && st[0]) m_ctrl[d] = wd[7:0];
            if (m_wrc[d] < 65535) m_wrc[d]++;
        end else begin
            case (a)
                8'h00:   e.dat = m_d0[d];
                8'h04:   e.dat = m_d1[d];
                8'h08:   e.dat = {24'd0, m_ctrl[d]};
                default: e.dat = {16'(m_errc[d]), 16'(m_wrc[d])};
            endcase
        end
        exp_q[d].push_back(e);
    endtask

    // Full transfer; leaves the bus in the access phase so a following call is back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
        int cyc;
        push_expect(d, wr, a, wd, st);
        @(posedge pclk); #1;
        psel_s[d] = 1; pen_s[d] = 0; pwr_s[d] = wr;
        paddr_s[d] = a; pwdata_s[d] = wd; pstrb_s[d] = st;
        @(posedge pclk); #1;
        pen_s[d] = 1;
        paddr_s[d] = 8'($urandom); pwdata_s[d] = $urandom; pstrb_s[d] = 4'($urandom);
        cyc = 1;
        forever begin
            @(negedge pclk);
            if (pready_s[d] || cyc >= 40) break;
            cyc++;
            @(posedge pclk); #1;
        end
        vectors++;
        if (!pready_s[d] || cyc != WS_OF[d] + 1) begin
            miscompares++;
            $display("FAIL latency dut%0d addr=%h: pready in access cycle %0d (seen=%b), required %0d",
                     d, a, cyc, pready_s[d], WS_OF[d] + 1);
        end
    endtask

    // Transfer abandoned after n access cycles (n < WAIT_STATES); nothing may complete.
    task automatic abort_xfer(input int d, input bit wr, input logic [7:0] a,
                              input logic [31:0] wd, input int n);
        @(posedge pclk); #1;
        psel_s[d] = 1; pen_s[d] = 0; pwr_s[d] = wr;
        paddr_s[d] = a; pwdata_s[d] = wd; pstrb_s[d] = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            pen_s[d] = 1;
        end
        @(posedge pclk); #1;
        psel_s[d] = 0; pen_s[d] = 0;
    endtask

    task automatic idle(input int d);
        @(posedge pclk); #1;
        psel_s[d] = 0; pen_s[d] = 0;
    endtask

    task automatic check_zero_outputs();
        @(negedge pclk);
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (pready_s[d] !== 1'b0 || prdata_s[d] !== 32'd0 || pslverr_s[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: pready=%b prdata=%h pslverr=%b, required all 0",
                         d, pready_s[d], prdata_s[d], pslverr_s[d]);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        preset = 1;
        for (int d = 0; d < NDUT; d++) begin
            psel_s[d] = 0; pen_s[d] = 0;
        end
        repeat (2) @(posedge pclk);
        #1 preset = 0;
        model_reset();
    endtask

    // Monitor: every pready pops one expected response; outside pready prdata must be 0.
    always @(negedge pclk) begin
        exp_t e;
        if (!preset) begin
            for (int d = 0; d < NDUT; d++) begin
                vectors++;
                if (pready_s[d]) begin
                    if (exp_q[d].size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_pready dut%0d: prdata=%h pslverr=%b, required no pready",
                                 d, prdata_s[d], pslverr_s[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        if (prdata_s[d] !== e.dat || pslverr_s[d] !== e.err) begin
                            miscompares++;
                            $display("FAIL response dut%0d: prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                                     d, prdata_s[d], pslverr_s[d], e.dat, e.err);
                        end
                    end
                end else if (prdata_s[d] !== 32'd0) begin
                    miscompares++;
                    $display("FAIL idle_prdata dut%0d: prdata=%h, required 0", d, prdata_s[d]);
                end
            end
        end
    end

    logic [7:0] ra;
    int         rd, last_d;

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            psel_s[d] = 0; pen_s[d] = 0; pwr_s[d] = 0;
            paddr_s[d] = 0; pwdata_s[d] = 0; pstrb_s[d] = 0;
        end
        model_reset();
        do_reset();
        check_zero_outputs();

        // Write then read back DATA0, then STATUS shows one write.
        xfer(0, 1, 8'h00, 32'h1234ABCD, 4'hF);
        xfer(0, 0, 8'h00, 32'h0, 4'h0);
        xfer(0, 0, 8'h0C, 32'h0, 4'h0);
        // Partial-lane write into zeroed DATA1.
        xfer(0, 1, 8'h04, 32'hFFFFFFFF, 4'b0101);
        xfer(0, 0, 8'h04, 32'h0, 4'h0);
        idle(0);

        // Error completions from a clean state: STATUS must read 0x0002_0000.
        do_reset();
        xfer(0, 1, 8'h0C, 32'hCAFEF00D, 4'hF);
        xfer(0, 0, 8'h11, 32'h0, 4'h0);
        xfer(0, 0, 8'h0C, 32'h0, 4'h0);

        // Aborted writes leave DATA0 and wr_cnt untouched (WAIT_STATES=1 and 3).
        abort_xfer(0, 1, 8'h00, 32'h5678EF01, 0);
        xfer(0, 0, 8'h00, 32'h0, 4'h0);
        xfer(0, 0, 8'h0C, 32'h0, 4'h0);
        idle(0);
        abort_xfer(2, 1, 8'h00, 32'h5678EF01, 2);
        xfer(2, 0, 8'h00, 32'h0, 4'h0);
        xfer(2, 0, 8'h0C, 32'h0, 4'h0);
        idle(2);

        // Zero wait states, back-to-back CTRL write/read, then an all-lanes-off write.
        xfer(1, 1, 8'h08, 32'hA5A5A5C3, 4'hF);
        xfer(1, 0, 8'h08, 32'h0, 4'h0);
        xfer(1, 1, 8'h00, 32'hFFFFFFFF, 4'h0);
        xfer(1, 0, 8'h00, 32'h0, 4'h0);
        xfer(1, 0, 8'h0C, 32'h0, 4'h0);
        idle(1);

        // penable without a setup phase must not start a transfer.
        @(posedge pclk); #1;
        psel_s[0] = 1; pen_s[0] = 1; pwr_s[0] = 1; paddr_s[0] = 8'h00; pwdata_s[0] = 32'hBAD0BAD0;
        repeat (3) @(posedge pclk);
        #1 psel_s[0] = 0; pen_s[0] = 0;
        xfer(0, 0, 8'h00, 32'h0, 4'h0);
        idle(0);

        // Reset during WAIT of a write: outputs clear and the target reads 0.
        xfer(2, 1, 8'h04, 32'h11112222, 4'hF);
        @(posedge pclk); #1;
        psel_s[2] = 1; pen_s[2] = 0; pwr_s[2] = 1; paddr_s[2] = 8'h04; pwdata_s[2] = 32'hDEADBEEF;
        pstrb_s[2] = 4'hF;
        @(posedge pclk); #1 pen_s[2] = 1;
        @(posedge pclk); #1 preset = 1;
        @(posedge pclk); #1 preset = 0;
        psel_s[2] = 0; pen_s[2] = 0;
        model_reset();
        check_zero_outputs();
        xfer(2, 0, 8'h04, 32'h0, 4'h0);
        xfer(2, 0, 8'h0C, 32'h0, 4'h0);
        idle(2);

        // Randomized traffic across all three instances.
        last_d = 2;
        for (int it = 0; it < 300; it++) begin
            rd = $urandom_range(0, NDUT - 1);
            if (rd != last_d) idle(last_d);
            last_d = rd;
            case ($urandom_range(0, 7))
                0, 1, 2, 3: ra = 8'($urandom_range(0, 3) * 4);
                4:          ra = 8'($urandom);
                5:          ra = 8'($urandom_range(0, 15));
                6:          ra = 8'h0C;
                default:    ra = 8'($urandom_range(0, 2) * 4);
            endcase
            if (WS_OF[rd] > 0 && $urandom_range(0, 9) == 0) begin
                abort_xfer(rd, 1'($urandom), ra, $urandom, $urandom_range(0, WS_OF[rd] - 1));
            end else begin
                xfer(rd, 1'($urandom), ra, $urandom, 4'($urandom));
                if ($urandom_range(0, 3) == 0) idle(rd);
            end
        end
        idle(last_d);
        for (int d = 0; d < NDUT; d++) xfer(d, 0, 8'h0C, 32'h0, 4'h0);
        for (int d = 0; d < NDUT; d++) idle(d);
        repeat (5) @(posedge pclk);

        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (exp_q[d].size() != 0) begin
                miscompares++;
                $display("FAIL drain dut%0d: %0d responses outstanding, required 0", d, exp_q[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL have the parameter WAIT_STATES, default 1, giving the number of access cycles inserted before pready (0..15).
REQ-002 pclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 preset  input  1  reset, synchronous and active-high.
REQ-004 psel  input  1  requester select.
REQ-005 penable  input  1  access-phase flag.
REQ-006 pwrite  input  1  1 = write, 0 = read.
REQ-007 paddr  input  8  byte address.
REQ-008 pwdata  input  32  write data.
REQ-009 pstrb  input  4  byte-lane write enables; pstrb[i] covers pwdata[8i+7:8i].
REQ-010 pready  output  1  transfer-complete, registered.
REQ-011 prdata  output  32  read data, registered.
REQ-012 pslverr  output  1  transfer error, registered, valid only while pready=1.

Function
REQ-013 The register map SHALL be: 0x00 DATA0 (RW), 0x04 DATA1 (RW), 0x08 CTRL (RW, bits [7:0] only, upper bits read 0), 0x0C STATUS (RO).
REQ-014 STATUS SHALL be {err_cnt[15:0], wr_cnt[15:0]}; wr_cnt increments on each successful write and err_cnt on each pslverr completion; both saturate at 0xFFFF.
REQ-015 The FSM SHALL have states IDLE, SETUP_SEEN, WAIT, and DONE.
REQ-016 IDLE -> SETUP_SEEN when psel=1 and penable=0; the block SHALL latch paddr, pwrite, pwdata, and pstrb at that edge.
REQ-017 SETUP_SEEN -> WAIT loads wait_cnt=WAIT_STATES; when WAIT_STATES=0 the FSM SHALL instead go directly to DONE, driving pready=1 in the first access cycle.
REQ-018 In WAIT, when psel=1 and penable=1, wait_cnt SHALL decrement each cycle; at wait_cnt==1 the FSM goes to DONE, so pready=1 appears in access cycle WAIT_STATES+1.
REQ-019 In DONE, pready=1 for exactly one cycle; a write SHALL commit to the register at the edge that ends this cycle.
REQ-020 Leaving DONE, the FSM SHALL go to SETUP_SEEN if psel=1 and penable=0 (back-to-back transfer), else to IDLE.
REQ-021 For reads, prdata SHALL hold the register value in the pready=1 cycle and 0 in every other cycle.
REQ-022 Write byte lanes SHALL update only where pstrb=1; pstrb=0000 on a write is a successful no-op that still increments wr_cnt.
REQ-023 pslverr=1 with pready SHALL result for paddr[1:0]!=0, for paddr>=0x10, or for a write to 0x0C; no register SHALL change, and prdata=0.
REQ-024 If psel falls in SETUP_SEEN or WAIT, the block SHALL abort to IDLE with no commit, no counter change, and pready=0.
REQ-025 penable=1 seen in IDLE without a prior setup SHALL be ignored.
REQ-026 Changes to paddr/pwdata after the setup edge SHALL NOT affect the transfer, since latched values are used.

Reset
REQ-027 preset=1 at a rising edge SHALL force: FSM=IDLE, pready=0, pslverr=0, prdata=0, DATA0=DATA1=CTRL=0, STATUS=0, wait_cnt=0.
REQ-028 Reset asserted mid-transfer SHALL abort that transfer with no commit; reset SHALL take priority over every other event at the same edge.

Verification
REQ-029 WAIT_STATES=1: write 0x1234ABCD to 0x00 with pstrb=F -> pready high in 2nd access cycle; a subsequent read of 0x00 returns 0x1234ABCD; STATUS=0x0000_0001.
REQ-030 Write 0xFFFFFFFF to 0x04 with pstrb=0101 after DATA1=0 -> read 0x04 returns 0x00FF00FF.
REQ-031 Write to 0x0C, then read 0x11 -> both complete with pslverr=1, prdata=0; STATUS=0x0002_0000 afterwards.
REQ-032 Drop psel during WAIT of a write of 0x5678EF01 to 0x00 -> no pready, DATA0 unchanged, wr_cnt unchanged.
REQ-033 WAIT_STATES=0, back-to-back write to 0x08 then read of 0x08 with no idle cycle -> pready in first access cycle of each, read returns only bits [7:0].
REQ-034 Assert preset during WAIT of a write -> all outputs 0 next cycle; a following read of the target register returns 0.
